// File: rtl/muldiv_seq_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_seq_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ACC_W    = 2 * XLEN;
  localparam int unsigned MD_ITERS = 32;
  localparam int unsigned CNT_W    = $clog2(MD_ITERS);

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

  // Magnitude of x; 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] abs_mag(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? (~x + XLEN'(1)) : x;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on the 64-bit accumulator.
module muldiv_step
  import muldiv_seq_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [XLEN-1:0]  operand,
  input  md_op_e           op,
  output logic [ACC_W-1:0] acc_next,
  output logic             qbit
);

  logic [XLEN:0] msum;
  logic [XLEN:0] partial;
  logic [XLEN:0] trial;

  // Divide leaves the quotient-bit slot (bit 0) clear; the caller ORs qbit in.
  always_comb begin
    msum     = {1'b0, acc[ACC_W-1:XLEN]};
    if (acc[0]) begin
      msum = msum + {1'b0, operand};
    end
    partial  = acc[ACC_W-1:XLEN-1];
    trial    = partial - {1'b0, operand};
    qbit     = 1'b0;
    acc_next = '0;
    if (op_is_div(op)) begin
      qbit     = ~trial[XLEN];
      acc_next = {(qbit ? trial[XLEN-1:0] : partial[XLEN-1:0]), acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {msum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/DIV sequencer with architected HI/LO and the busy handshake to the pipeline.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            mdstartE,
  input  logic [1:0]      mdopE,
  input  logic [1:0]      mtE,
  input  logic [XLEN-1:0] srcaE,
  input  logic [XLEN-1:0] srcbE,
  input  logic            stallE,
  input  logic            flushE,
  input  logic            mdcancel,
  output logic            mdrunE,
  output logic [XLEN-1:0] hiE,
  output logic [XLEN-1:0] loE,
  output logic            mddone
);

  md_state_e        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [ACC_W-1:0] acc, acc_d;
  logic [XLEN-1:0]  opnd, opnd_d;
  logic [XLEN-1:0]  a_orig, a_orig_d;
  md_op_e           op_q, op_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [XLEN-1:0]  hi_d, lo_d;
  logic             run;

  logic             accept;
  logic             mt_ok;
  md_op_e           op_in;
  logic             sgn_in;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [ACC_W-1:0] step_acc;
  logic             step_q;

  assign op_in  = md_op_e'(mdopE);
  assign accept = mdstartE & ~stallE & ~flushE & ~mdcancel;
  assign mt_ok  = ~mdstartE & ~stallE & ~flushE;
  assign sgn_in = op_is_signed(op_in);
  assign a_mag  = abs_mag(srcaE, sgn_in);
  assign b_mag  = abs_mag(srcbE, sgn_in);
  assign mdrunE = run;

  muldiv_step u_step (
    .acc      (acc),
    .operand  (opnd),
    .op       (op_q),
    .acc_next (step_acc),
    .qbit     (step_q)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_orig <= '0;
      op_q   <= MD_MULT;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      hiE    <= '0;
      loE    <= '0;
      run    <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_d;
      acc    <= acc_d;
      opnd   <= opnd_d;
      a_orig <= a_orig_d;
      op_q   <= op_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      hiE    <= hi_d;
      loE    <= lo_d;
      run    <= (state_next != IDLE);
    end
  end

  // Next-state logic; cancel wins over both iteration and commit.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = RUN;
      RUN: begin
        if (mdcancel) begin
          state_next = IDLE;
        end else if (cnt == CNT_W'(MD_ITERS - 1)) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath updates, HI/LO commit and the done pulse.
  always_comb begin
    cnt_d    = cnt;
    acc_d    = acc;
    opnd_d   = opnd;
    a_orig_d = a_orig;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hiE;
    lo_d     = loE;
    mddone   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          op_d     = op_in;
          neg_d    = sgn_in & (srcaE[XLEN-1] ^ srcbE[XLEN-1]);
          rneg_d   = sgn_in & srcaE[XLEN-1];
          dz_d     = op_is_div(op_in) & (srcbE == '0);
          a_orig_d = srcaE;
          cnt_d    = '0;
          // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
          if (op_is_div(op_in)) begin
            acc_d  = {XLEN'(0), a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {XLEN'(0), b_mag};
            opnd_d = a_mag;
          end
        end else if (mt_ok) begin
          if (mtE[1]) hi_d = srcaE;
          if (mtE[0]) lo_d = srcaE;
        end
      end
      RUN: begin
        if (!mdcancel) begin
          acc_d = step_acc | {(ACC_W - 1)'(0), step_q};
          cnt_d = cnt + CNT_W'(1);
        end
      end
      FIX: begin
        if (!mdcancel) begin
          mddone = 1'b1;
          if (dz_q) begin
            hi_d = a_orig;
            lo_d = '1;
          end else if (op_is_div(op_q)) begin
            lo_d = neg_q  ? (~acc[XLEN-1:0] + XLEN'(1))     : acc[XLEN-1:0];
            hi_d = rneg_q ? (~acc[ACC_W-1:XLEN] + XLEN'(1)) : acc[ACC_W-1:XLEN];
          end else begin
            {hi_d, lo_d} = neg_q ? (~acc + ACC_W'(1)) : acc;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: arithmetic, timing, MT, cancel, reset and stall cases.
module tb_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        mdstartE;
  logic [1:0]  mdopE;
  logic [1:0]  mtE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        stallE;
  logic        flushE;
  logic        mdcancel;
  logic        mdrunE;
  logic [31:0] hiE;
  logic [31:0] loE;
  logic        mddone;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_seq dut (
    .clk      (clk),
    .reset    (reset),
    .mdstartE (mdstartE),
    .mdopE    (mdopE),
    .mtE      (mtE),
    .srcaE    (srcaE),
    .srcbE    (srcbE),
    .stallE   (stallE),
    .flushE   (flushE),
    .mdcancel (mdcancel),
    .mdrunE   (mdrunE),
    .hiE      (hiE),
    .loE      (loE),
    .mddone   (mddone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op in cycle 0 and check busy/done timing plus the committed HI/LO in cycle 34.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                        input int stray, input string tag);
    int run_ok  = 1;
    int hold_ok = 1;
    int done_n  = 0;
    int done_at = -1;
    mdopE    = op;
    srcaE    = a;
    srcbE    = b;
    mdstartE = 1'b1;
    tick();
    for (int c = 1; c <= 33; c++) begin
      if (c == stray) begin
        mdstartE = 1'b1;
        mdopE    = 2'b00;
        srcaE    = 32'h3;
        srcbE    = 32'h3;
      end else begin
        mdstartE = 1'b0;
      end
      if (!mdrunE) run_ok = 0;
      if (mddone) begin
        done_n++;
        done_at = c;
      end
      if (hiE !== hold_hi || loE !== hold_lo) hold_ok = 0;
      tick();
    end
    mdstartE = 1'b0;
    check_eq({tag, "_run_high"}, 64'(run_ok), 64'd1);
    check_eq({tag, "_hilo_hold"}, 64'(hold_ok), 64'd1);
    check_eq({tag, "_done_count"}, 64'(done_n), 64'd1);
    check_eq({tag, "_done_cycle"}, 64'(done_at), 64'd33);
    check_eq({tag, "_run_low"}, 64'(mdrunE), 64'd0);
    check_eq({tag, "_hi"}, 64'(hiE), 64'(ehi));
    check_eq({tag, "_lo"}, 64'(loE), 64'(elo));
  endtask

  initial begin
    int done_n;
    reset    = 1'b1;
    mdstartE = 1'b0;
    mdopE    = 2'b00;
    mtE      = 2'b00;
    srcaE    = '0;
    srcbE    = '0;
    stallE   = 1'b0;
    flushE   = 1'b0;
    mdcancel = 1'b0;
    tick();
    tick();
    check_eq("reset_hi", 64'(hiE), 64'd0);
    check_eq("reset_lo", 64'(loE), 64'd0);
    check_eq("reset_run", 64'(mdrunE), 64'd0);
    check_eq("reset_done", 64'(mddone), 64'd0);
    reset = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h0, 32'h0, -1, "mult_neg");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, -1, "multu_max");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           32'hFFFF_FFFE, 32'h0000_0001, -1, "div_neg7_2");
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "divu_100_7");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'd2, 32'd14, -1, "div_ovf");
    run_op(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, -1, "divu_by0");
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF,
           32'd5, 32'hFFFF_FFFF, -1, "div_by0");
    run_op(2'b10, 32'd9, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFC,
           32'hFFFF_FFFB, 32'hFFFF_FFFF, -1, "div_9_neg2");

    // MTHI in idle, then a MULT aborted at cycle 20 with a stray start at cycle 10.
    mtE   = 2'b10;
    srcaE = 32'h1234;
    tick();
    mtE = 2'b00;
    check_eq("mthi_hi", 64'(hiE), 64'h1234);
    check_eq("mthi_lo_kept", 64'(loE), 64'hFFFF_FFFC);
    mdopE    = 2'b00;
    srcaE    = 32'd2;
    srcbE    = 32'd3;
    mdstartE = 1'b1;
    tick();
    done_n = 0;
    for (int c = 1; c <= 20; c++) begin
      mdstartE = (c == 10);
      mdcancel = (c == 20);
      #1;
      if (mddone) done_n++;
      tick();
    end
    mdstartE = 1'b0;
    mdcancel = 1'b0;
    check_eq("cancel_run_low", 64'(mdrunE), 64'd0);
    check_eq("cancel_hi_kept", 64'(hiE), 64'h1234);
    for (int c = 0; c < 20; c++) begin
      if (mddone) done_n++;
      tick();
    end
    check_eq("cancel_no_done", 64'(done_n), 64'd0);
    check_eq("cancel_lo_kept", 64'(loE), 64'hFFFF_FFFC);

    // Cancel landing in the commit cycle must suppress the commit.
    mdopE    = 2'b01;
    srcaE    = 32'd7;
    srcbE    = 32'd6;
    mdstartE = 1'b1;
    tick();
    mdstartE = 1'b0;
    repeat (32) tick();
    mdcancel = 1'b1;
    #1;
    check_eq("fixcancel_done", 64'(mddone), 64'd0);
    tick();
    mdcancel = 1'b0;
    check_eq("fixcancel_run", 64'(mdrunE), 64'd0);
    check_eq("fixcancel_lo", 64'(loE), 64'hFFFF_FFFC);

    // Stalled or flushed start and MT are not taken.
    mdstartE = 1'b1;
    stallE   = 1'b1;
    tick();
    check_eq("stall_no_start", 64'(mdrunE), 64'd0);
    stallE = 1'b0;
    flushE = 1'b1;
    tick();
    check_eq("flush_no_start", 64'(mdrunE), 64'd0);
    mdstartE = 1'b0;
    mtE      = 2'b01;
    srcaE    = 32'hABCD;
    tick();
    flushE = 1'b0;
    mtE    = 2'b00;
    check_eq("flush_no_mt", 64'(loE), 64'hFFFF_FFFC);
    mtE = 2'b01;
    tick();
    mtE = 2'b00;
    check_eq("mtlo_lo", 64'(loE), 64'hABCD);

    // Reset in the middle of a DIVU.
    mdopE    = 2'b11;
    srcaE    = 32'd100;
    srcbE    = 32'd7;
    mdstartE = 1'b1;
    tick();
    mdstartE = 1'b0;
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midreset_run", 64'(mdrunE), 64'd0);
    check_eq("midreset_hi", 64'(hiE), 64'd0);
    check_eq("midreset_lo", 64'(loE), 64'd0);
    done_n = 0;
    for (int c = 0; c < 25; c++) begin
      if (mddone || mdrunE) done_n++;
      tick();
    end
    check_eq("midreset_quiet", 64'(done_n), 64'd0);

    run_op(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 32'h0, 32'h0, -1, "mult_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
